cflog_wr_arbiter: RTL and testbench
===================================

CFLOG_WR_ARBITER -- requirements
Module: cflog_wr_arbiter

Interface
REQ-001 Parameter CFLOW_LOGS_SIZE, default 16'h80: number of 16-bit log words.
REQ-002 Parameter ADDR_MSB, default 7: MSB of mem_addr.
REQ-003 mclk  in  1  single clock; all state on rising edge.
REQ-004 puc_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 cfa_req  in  1  CFA requester wants one (src,dest) pair written.
REQ-006 cfa_ptr  in  16  CFA log pointer; pair goes to words ptr-2, ptr-1.
REQ-007 cfa_src, cfa_dest  in  16 each  CFA pair data.
REQ-008 cfa_ack  out  1  one-cycle completion/drop pulse to CFA.
REQ-009 spec_req, spec_ptr, spec_upper, spec_lower, spec_ack: Spec-CFA channel, same widths and meaning as REQ-005..008.
REQ-010 mem_we  out  1  single write strobe to log memory.
REQ-011 mem_addr  out  ADDR_MSB+1  log word index.
REQ-012 mem_wdata  out  16  word written.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 ovf  out  1  sticky flag, set when a request is dropped.
REQ-015 ovf_clr  in  1  synchronous clear of ovf.

Function
REQ-016 FSM states IDLE, WR0, WR1, DROP; all outputs SHALL be decoded from registered state and registered latched data.
REQ-017 In IDLE with at least one req high, the FSM SHALL grant round-robin: if both are high, the requester not granted last wins; after reset, CFA counts as "last granted = spec".
REQ-018 On grant, the FSM SHALL latch the winner's ptr, data words and grant id; later input changes SHALL NOT affect the transfer.
REQ-019 base = ptr - 16'h2, modulo 2^16; the request is in range iff base < CFLOW_LOGS_SIZE-1, so that both base and base+1 are below CFLOW_LOGS_SIZE.
REQ-020 In range: IDLE->WR0->WR1->IDLE; out of range: IDLE->DROP->IDLE.
REQ-021 In WR0: mem_we=1, mem_addr=base, mem_wdata=word0 (src/upper).
REQ-022 In WR1: mem_we=1, mem_addr=base+1, mem_wdata=word1 (dest/lower), and the granted ack=1.
REQ-023 In DROP: mem_we=0, granted ack=1, and ovf is set at the end of the cycle.
REQ-024 Latency: req sampled in cycle N; first word written in N+1; second word and ack in N+2.
REQ-025 A requester SHALL deassert req, or present a new request, at the edge ending its ack cycle; the FSM samples in IDLE at N+3.
REQ-026 Outside WR0/WR1, mem_we=0, mem_addr=0 and mem_wdata=0.
REQ-027 ovf_clr and a DROP in the same cycle: set wins, ovf=1.
REQ-028 At most one ack SHALL be high in any cycle; acks SHALL never be high in IDLE or WR0.

Reset
REQ-029 puc_rst_n low SHALL immediately force state=IDLE, mem_we=0, acks=0, busy=0, ovf=0, last-grant=spec, and all latched data to 0.
REQ-030 Reset mid-transfer SHALL abort the transfer without ack; the requester re-requests after reset.

Structure
REQ-031 Package cflog_pkg SHALL hold the FSM state encoding, grant-id constants and the CFLOW_LOGS_SIZE default, so it can be shared with the cflog memory block.
REQ-032 No sub-module; round-robin grant and range check SHALL be inline.

Verification
REQ-033 cfa_req, ptr=0x0004, src=0xE000, dest=0xE010 -> N+1: we, addr 0x02, data 0xE000; N+2: we, addr 0x03, data 0xE010, cfa_ack=1.
REQ-034 After reset, both req same cycle (spec ptr=0x0010) -> CFA written first, then spec to 0x0E/0x0F; both again -> spec first.
REQ-035 Range boundaries:
- spec ptr=0x0081 -> DROP, no mem_we, spec_ack, ovf=1.
- ptr=0x0080 -> writes at 0x7E and 0x7F.
REQ-036 ptr=0x0001 (base wraps to 0xFFFF) -> DROP, ovf=1.
REQ-037 puc_rst_n low during WR0 -> mem_we=0 at once, no ack, ovf=0, state IDLE.
REQ-038 ovf_clr asserted in a DROP cycle -> ovf=1; ovf_clr alone next cycle -> ovf=0.

Source files
------------

// File: rtl/cflog_pkg.sv
// Shared definitions for the control-flow log write path and log memory.
// Holds the arbiter FSM encoding, grant-id constants, the default log size
// and the latched (word0, word1) pair payload type.
package cflog_pkg;

  localparam int unsigned WORD_W = 16;

  // Default number of 16-bit log words.
  localparam logic [WORD_W-1:0] CFLOW_LOGS_SIZE_DFLT = 16'h0080;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR0  = 2'd1,
    ST_WR1  = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  // Grant ids; after reset the last grant is taken to be the Spec-CFA channel.
  localparam logic GNT_CFA  = 1'b0;
  localparam logic GNT_SPEC = 1'b1;

  // One log pair: word0 (src / upper) goes to base, word1 (dest / lower) to base+1.
  typedef struct packed {
    logic [WORD_W-1:0] w0;
    logic [WORD_W-1:0] w1;
  } pair_t;

endpackage

// File: rtl/cflog_wr_arbiter_if.sv
// Bus bundle between the two log requesters (CFA, Spec-CFA), the log memory
// write port and the status/overflow signals of cflog_wr_arbiter.
//   master : requester / memory side (drives req, ptr, data, ovf_clr)
//   slave  : arbiter side (drives acks, mem_we/addr/wdata, busy, ovf)
interface cflog_wr_arbiter_if
  import cflog_pkg::*;
#(
  parameter int unsigned ADDR_MSB = 7
);

  logic              cfa_req;
  logic [WORD_W-1:0] cfa_ptr;
  logic [WORD_W-1:0] cfa_src;
  logic [WORD_W-1:0] cfa_dest;
  logic              cfa_ack;

  logic              spec_req;
  logic [WORD_W-1:0] spec_ptr;
  logic [WORD_W-1:0] spec_upper;
  logic [WORD_W-1:0] spec_lower;
  logic              spec_ack;

  logic              mem_we;
  logic [ADDR_MSB:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;

  logic              busy;
  logic              ovf;
  logic              ovf_clr;

  modport master (
    output cfa_req, cfa_ptr, cfa_src, cfa_dest,
    output spec_req, spec_ptr, spec_upper, spec_lower,
    output ovf_clr,
    input  cfa_ack, spec_ack, mem_we, mem_addr, mem_wdata, busy, ovf
  );

  modport slave (
    input  cfa_req, cfa_ptr, cfa_src, cfa_dest,
    input  spec_req, spec_ptr, spec_upper, spec_lower,
    input  ovf_clr,
    output cfa_ack, spec_ack, mem_we, mem_addr, mem_wdata, busy, ovf
  );

endinterface

// File: rtl/cflog_wr_arbiter.sv
// Round-robin write arbiter for the control-flow log memory.
// Two requesters (CFA, Spec-CFA) each ask for one 16-bit pair to be written
// at words ptr-2 / ptr-1. A granted in-range request takes two write cycles
// (WR0, WR1 + ack); an out-of-range request is acked in DROP without writing
// and sets the sticky ovf flag.
// Ports:
//   mclk      : clock
//   puc_rst_n : asynchronous active-low reset
//   bus       : cflog_wr_arbiter_if.slave (requests/acks, memory port, busy/ovf)
module cflog_wr_arbiter
  import cflog_pkg::*;
#(
  parameter logic [WORD_W-1:0] CFLOW_LOGS_SIZE = CFLOW_LOGS_SIZE_DFLT,
  parameter int unsigned       ADDR_MSB        = 7
) (
  input logic               mclk,
  input logic               puc_rst_n,
  cflog_wr_arbiter_if.slave bus
);

  localparam int unsigned AW = ADDR_MSB + 1;

  state_t            state_q;
  state_t            state_d;
  logic              gnt_q;     // grant id of the current/last transfer
  logic [AW-1:0]     addr_q;
  pair_t             data_q;
  logic              ovf_q;

  logic              any_req_c;
  logic              gnt_c;
  logic [WORD_W-1:0] ptr_c;
  logic [WORD_W-1:0] base_c;
  pair_t             pair_c;
  logic              in_range_c;

  // Round-robin pick and range check of the winner's pointer.
  always_comb begin
    any_req_c  = bus.cfa_req | bus.spec_req;
    gnt_c      = GNT_CFA;
    if (bus.cfa_req && bus.spec_req) begin
      gnt_c = (gnt_q == GNT_SPEC) ? GNT_CFA : GNT_SPEC;
    end else if (bus.spec_req) begin
      gnt_c = GNT_SPEC;
    end
    if (gnt_c == GNT_SPEC) begin
      ptr_c     = bus.spec_ptr;
      pair_c.w0 = bus.spec_upper;
      pair_c.w1 = bus.spec_lower;
    end else begin
      ptr_c     = bus.cfa_ptr;
      pair_c.w0 = bus.cfa_src;
      pair_c.w1 = bus.cfa_dest;
    end
    // Wraps modulo 2^16, so ptr 0/1 lands far out of range.
    base_c     = ptr_c - 16'h0002;
    // base+1 must also fit, hence the strict compare against SIZE-1.
    in_range_c = (base_c < (CFLOW_LOGS_SIZE - 16'h0001));
  end

  // State register.
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req_c) begin
          state_d = in_range_c ? ST_WR0 : ST_DROP;
        end
      end
      ST_WR0:  state_d = ST_WR1;
      ST_WR1:  state_d = ST_IDLE;
      ST_DROP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Latch the winner on grant; later input changes do not disturb the transfer.
  // gnt_q doubles as the round-robin "last granted" id, reset to Spec-CFA.
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      gnt_q  <= GNT_SPEC;
      addr_q <= '0;
      data_q <= '0;
    end else if ((state_q == ST_IDLE) && any_req_c) begin
      gnt_q  <= gnt_c;
      addr_q <= AW'(base_c);
      data_q <= pair_c;
    end
  end

  // Sticky overflow; a drop in the same cycle beats the clear.
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      ovf_q <= 1'b0;
    end else if (state_q == ST_DROP) begin
      ovf_q <= 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  // Output decode from registered state and latched data only.
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.cfa_ack   = 1'b0;
    bus.spec_ack  = 1'b0;
    bus.busy      = (state_q != ST_IDLE);
    bus.ovf       = ovf_q;
    case (state_q)
      ST_WR0: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = data_q.w0;
      end
      ST_WR1: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = addr_q + AW'(1);
        bus.mem_wdata = data_q.w1;
        bus.cfa_ack   = (gnt_q == GNT_CFA);
        bus.spec_ack  = (gnt_q == GNT_SPEC);
      end
      ST_DROP: begin
        bus.cfa_ack   = (gnt_q == GNT_CFA);
        bus.spec_ack  = (gnt_q == GNT_SPEC);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cflog_wr_arbiter.sv
// Self-checking bench for cflog_wr_arbiter: directed boundary scenarios
// followed by randomized two-requester traffic, all compared each cycle
// against a transaction-level model that expands each grant into the list
// of expected output cycles.
module tb_cflog_wr_arbiter;
  import cflog_pkg::*;

  localparam int LOGS = 128;

  logic mclk = 1'b0;
  logic puc_rst_n;
  always #5 mclk = ~mclk;

  cflog_wr_arbiter_if #(.ADDR_MSB(7)) bus ();

  cflog_wr_arbiter #(.CFLOW_LOGS_SIZE(16'h0080), .ADDR_MSB(7)) dut (
    .mclk      (mclk),
    .puc_rst_n (puc_rst_n),
    .bus       (bus)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // One expected output cycle.
  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
    logic        cack;
    logic        sack;
    logic        drop;
  } exp_t;

  exp_t exp_q[$];
  bit   m_last_spec;
  bit   m_ovf;
  bit   cur_cack, cur_sack;

  task automatic model_reset();
    exp_q.delete();
    m_last_spec = 1'b1;
    m_ovf       = 1'b0;
  endtask

  // Called at each rising edge with the inputs that edge samples.
  task automatic model_edge();
    exp_t e;
    bit was_idle, drop_done, pick_spec;
    int ptr, base;
    logic [15:0] w0, w1;
    was_idle  = (exp_q.size() == 0);
    drop_done = 1'b0;
    if (!was_idle) begin
      e = exp_q.pop_front();
      drop_done = e.drop;
    end
    if (drop_done) m_ovf = 1'b1;
    else if (bus.ovf_clr) m_ovf = 1'b0;
    if (was_idle && (bus.cfa_req || bus.spec_req)) begin
      pick_spec   = bus.spec_req && (!bus.cfa_req || !m_last_spec);
      m_last_spec = pick_spec;
      ptr  = pick_spec ? int'(bus.spec_ptr)   : int'(bus.cfa_ptr);
      w0   = pick_spec ? bus.spec_upper       : bus.cfa_src;
      w1   = pick_spec ? bus.spec_lower       : bus.cfa_dest;
      base = (ptr + 65536 - 2) % 65536;
      if (base + 1 < LOGS) begin
        exp_q.push_back('{1'b1, 16'(base),     w0, 1'b0, 1'b0, 1'b0});
        exp_q.push_back('{1'b1, 16'(base + 1), w1, !pick_spec, pick_spec, 1'b0});
      end else begin
        exp_q.push_back('{1'b0, 16'h0, 16'h0, !pick_spec, pick_spec, 1'b1});
      end
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    e = '{1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0};
    if (exp_q.size() != 0) e = exp_q[0];
    check("mem_we",    32'(bus.mem_we),    32'(e.we));
    check("mem_addr",  32'(bus.mem_addr),  32'(e.addr));
    check("mem_wdata", 32'(bus.mem_wdata), 32'(e.data));
    check("cfa_ack",   32'(bus.cfa_ack),   32'(e.cack));
    check("spec_ack",  32'(bus.spec_ack),  32'(e.sack));
    check("busy",      32'(bus.busy),      32'(exp_q.size() != 0));
    check("ovf",       32'(bus.ovf),       32'(m_ovf));
    cur_cack = e.cack;
    cur_sack = e.sack;
  endtask

  // Advance one clock; outputs are checked on the falling edge.
  task automatic tick();
    @(posedge mclk);
    model_edge();
    @(negedge mclk);
    check_outputs();
  endtask

  task automatic idle_inputs();
    bus.cfa_req = 1'b0;  bus.cfa_ptr = '0;  bus.cfa_src = '0;    bus.cfa_dest = '0;
    bus.spec_req = 1'b0; bus.spec_ptr = '0; bus.spec_upper = '0; bus.spec_lower = '0;
    bus.ovf_clr = 1'b0;
  endtask

  // Called at a falling edge; returns at the next falling edge out of reset.
  task automatic do_reset();
    idle_inputs();
    puc_rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge mclk);
    puc_rst_n = 1'b1;
  endtask

  task automatic drive_cfa(input logic [15:0] p, input logic [15:0] s, input logic [15:0] d);
    bus.cfa_req = 1'b1; bus.cfa_ptr = p; bus.cfa_src = s; bus.cfa_dest = d;
  endtask

  task automatic drive_spec(input logic [15:0] p, input logic [15:0] u, input logic [15:0] l);
    bus.spec_req = 1'b1; bus.spec_ptr = p; bus.spec_upper = u; bus.spec_lower = l;
  endtask

  function automatic logic [15:0] rand_ptr();
    case ($urandom_range(9, 0))
      0: return 16'h0000;
      1: return 16'h0001;
      2: return 16'h0080;
      3: return 16'h0081;
      4: return 16'h0082;
      5: return 16'($urandom);
      default: return 16'(2 + $urandom_range(127, 0));
    endcase
  endfunction

  bit c_act, s_act;

  initial begin
    puc_rst_n = 1'b0;
    idle_inputs();
    model_reset();
    #12;
    check_outputs();
    @(negedge mclk);
    puc_rst_n = 1'b1;
    tick();

    // Single CFA pair; inputs scrambled after grant must not matter.
    drive_cfa(16'h0004, 16'hE000, 16'hE010);
    tick();
    check("r33_addr0", 32'(bus.mem_addr), 32'h02);
    check("r33_data0", 32'(bus.mem_wdata), 32'hE000);
    bus.cfa_ptr = 16'h0050; bus.cfa_src = 16'h1234; bus.cfa_dest = 16'h5678;
    tick();
    check("r33_addr1", 32'(bus.mem_addr), 32'h03);
    check("r33_data1", 32'(bus.mem_wdata), 32'hE010);
    check("r33_ack",   32'(bus.cfa_ack), 32'h1);
    bus.cfa_req = 1'b0;
    tick();

    // Simultaneous requests after reset: CFA first, then Spec-CFA.
    do_reset();
    drive_cfa(16'h0004, 16'hA001, 16'hA002);
    drive_spec(16'h0010, 16'hB001, 16'hB002);
    tick();
    tick();
    check("r34_cack", 32'(bus.cfa_ack), 32'h1);
    drive_cfa(16'h0020, 16'hC001, 16'hC002);
    tick();
    tick();
    check("r34_spec_addr0", 32'(bus.mem_addr), 32'h0E);
    tick();
    check("r34_spec_addr1", 32'(bus.mem_addr), 32'h0F);
    check("r34_sack", 32'(bus.spec_ack), 32'h1);
    bus.spec_req = 1'b0;
    tick();
    tick();
    check("r34_cfa2_addr0", 32'(bus.mem_addr), 32'h1E);
    tick();
    bus.cfa_req = 1'b0;
    tick();

    // Range boundaries.
    drive_spec(16'h0081, 16'h1111, 16'h2222);
    tick();
    check("r35_drop_we",   32'(bus.mem_we), 32'h0);
    check("r35_drop_sack", 32'(bus.spec_ack), 32'h1);
    bus.spec_req = 1'b0;
    tick();
    check("r35_ovf", 32'(bus.ovf), 32'h1);
    drive_cfa(16'h0080, 16'h3333, 16'h4444);
    tick();
    check("r35_top_addr0", 32'(bus.mem_addr), 32'h7E);
    tick();
    check("r35_top_addr1", 32'(bus.mem_addr), 32'h7F);
    bus.cfa_req = 1'b0;
    bus.ovf_clr = 1'b1;
    tick();
    tick();
    check("ovf_cleared", 32'(bus.ovf), 32'h0);
    bus.ovf_clr = 1'b0;

    // Wrapping base, with clear coinciding with the drop cycle.
    drive_cfa(16'h0001, 16'h5555, 16'h6666);
    tick();
    check("r36_drop_cack", 32'(bus.cfa_ack), 32'h1);
    bus.cfa_req = 1'b0;
    bus.ovf_clr = 1'b1;
    tick();
    check("r38_set_wins", 32'(bus.ovf), 32'h1);
    tick();
    check("r38_clr_alone", 32'(bus.ovf), 32'h0);
    bus.ovf_clr = 1'b0;

    // Reset during WR0 with ovf set beforehand.
    drive_spec(16'h0000, 16'h7777, 16'h8888);
    tick();
    bus.spec_req = 1'b0;
    tick();
    drive_cfa(16'h0010, 16'h9999, 16'hAAAA);
    tick();
    check("r37_in_wr0", 32'(bus.mem_we), 32'h1);
    puc_rst_n = 1'b0;
    bus.cfa_req = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("r37_we",   32'(bus.mem_we), 32'h0);
    check("r37_ovf",  32'(bus.ovf), 32'h0);
    check("r37_busy", 32'(bus.busy), 32'h0);
    @(posedge mclk);
    @(negedge mclk);
    check_outputs();
    puc_rst_n = 1'b1;
    tick();

    // Randomized traffic from both requesters.
    c_act = 1'b0;
    s_act = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cur_cack)    c_act = ($urandom_range(1, 0) == 1);
      else if (!c_act) c_act = ($urandom_range(2, 0) == 0);
      if (cur_sack)    s_act = ($urandom_range(1, 0) == 1);
      else if (!s_act) s_act = ($urandom_range(2, 0) == 0);
      bus.cfa_req    = c_act;
      bus.cfa_ptr    = rand_ptr();
      bus.cfa_src    = 16'($urandom);
      bus.cfa_dest   = 16'($urandom);
      bus.spec_req   = s_act;
      bus.spec_ptr   = rand_ptr();
      bus.spec_upper = 16'($urandom);
      bus.spec_lower = 16'($urandom);
      bus.ovf_clr    = ($urandom_range(7, 0) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
